// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams 32-bit instruction words into a byte-addressed
// instruction memory. Each word is split big-endian into four byte writes,
// most significant byte at the lowest address. All outputs are Moore-decoded.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int BASE_ADDR  = 0,  // multiple of 4
  parameter int MEM_BYTES  = 256 // multiple of 4, at least 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  word_valid,
  input  logic [31:0]           word_data,
  input  logic                  word_last,
  output logic                  word_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           words_loaded
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  // One past the last usable byte; wraps modulo 2^ADDR_WIDTH like ptr does.
  localparam logic [ADDR_WIDTH-1:0] LIMIT = BASE + ADDR_WIDTH'(MEM_BYTES);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [31:0]           word_q;
  logic                  last_q;
  logic [1:0]            beat;
  logic                  full;

  // ptr only ever advances in whole words, so equality with LIMIT is enough.
  assign full = (ptr == LIMIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement or process order.
      state <= state_next;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_next = state;
    word_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ACCEPT;
      end
      ACCEPT: begin
        busy = 1'b1;
        if (full) begin
          state_next = DONE;
        end else begin
          word_ready = 1'b1;
          if (word_valid) state_next = WRITE;
        end
      end
      WRITE: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = ptr;
        case (beat)
          2'd0:    mem_wdata = word_q[31:24];
          2'd1:    mem_wdata = word_q[23:16];
          2'd2:    mem_wdata = word_q[15:8];
          default: mem_wdata = word_q[7:0];
        endcase
        if (beat == 2'd3) state_next = last_q ? DONE : ACCEPT;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: write pointer, latched word, beat counter and session status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= BASE;
      word_q       <= 32'h0;
      last_q       <= 1'b0;
      beat         <= 2'd0;
      words_loaded <= 16'h0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr          <= BASE;
            words_loaded <= 16'h0;
            overflow     <= 1'b0;
          end
        end
        ACCEPT: begin
          if (full) begin
            overflow <= 1'b1;
          end else if (word_valid) begin
            word_q <= word_data;
            last_q <= word_last;
            beat   <= 2'd0;
          end
        end
        WRITE: begin
          ptr  <= ptr + ADDR_WIDTH'(1);
          beat <= beat + 2'd1;
          if (beat == 2'd3 && words_loaded != 16'hFFFF) begin
            words_loaded <= words_loaded + 16'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader. Three instances share the word stream
// and reset: dut 0 is the default map, dut 1 has an 8-byte space, dut 2 starts
// at byte 16. Each has its own start, so only one is active at a time.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_q [3];
  logic word_valid;
  logic [31:0] word_data;
  logic word_last;

  logic        wr    [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [7:0]  wdata [3];
  logic        busy  [3];
  logic        done  [3];
  logic        ovf   [3];
  logic [15:0] wl    [3];

  logic [7:0]  mem [3][512];
  logic        clr_mem;
  int          hs [3];
  int          viol;
  int          cyc;
  int          log_n;
  logic [31:0] log_addr [8];
  logic [7:0]  log_data [8];

  int n_pass;
  int n_total;

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_WIDTH(32), .BASE_ADDR(0), .MEM_BYTES(256)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_q[0]), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(wr[0]),
    .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]), .busy(busy[0]),
    .done(done[0]), .overflow(ovf[0]), .words_loaded(wl[0]));

  instr_mem_loader #(.ADDR_WIDTH(32), .BASE_ADDR(0), .MEM_BYTES(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_q[1]), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(wr[1]),
    .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]), .busy(busy[1]),
    .done(done[1]), .overflow(ovf[1]), .words_loaded(wl[1]));

  instr_mem_loader #(.ADDR_WIDTH(32), .BASE_ADDR(16), .MEM_BYTES(256)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_q[2]), .word_valid(word_valid),
    .word_data(word_data), .word_last(word_last), .word_ready(wr[2]),
    .mem_we(we[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]), .busy(busy[2]),
    .done(done[2]), .overflow(ovf[2]), .words_loaded(wl[2]));

  // Byte memories, handshake counters, overlap monitor and dut 2 write log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0 && clr_mem) begin
        for (int i = 0; i < 512; i++) mem[0][i] <= 8'h00;
      end else if (we[k]) begin
        mem[k][addr[k][8:0]] <= wdata[k];
      end
      if (word_valid && wr[k]) hs[k] <= hs[k] + 1;
      if (wr[k] && we[k]) viol <= viol + 1;
    end
    if (we[2] && log_n < 8) begin
      log_addr[log_n] <= addr[2];
      log_data[log_n] <= wdata[2];
      log_n <= log_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pulse_start(input int sel, output int st);
    @(negedge clk);
    start_q[sel] = 1'b1;
    @(posedge clk);
    #1;
    st = cyc;
    start_q[sel] = 1'b0;
  endtask

  // Presents a word after 'gap' idle cycles and returns just after the handshake edge.
  task automatic send_word(input int sel, input logic [31:0] d, input logic l,
                           input int gap, output logic ok);
    int budget;
    @(negedge clk);
    if (gap > 0) begin
      word_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    budget = 0;
    ok = 1'b0;
    while (!wr[sel] && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (wr[sel]) begin
      ok = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int sel, output int at, output logic seen);
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done[sel]) begin
        seen = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(wr[0]), 32'h0);
    check({tag, "_we"},    32'(we[0]), 32'h0);
    check({tag, "_addr"},  addr[0],    32'h0);
    check({tag, "_wdata"}, 32'(wdata[0]), 32'h0);
    check({tag, "_busy"},  32'(busy[0]), 32'h0);
    check({tag, "_done"},  32'(done[0]), 32'h0);
    check({tag, "_ovf"},   32'(ovf[0]),  32'h0);
    check({tag, "_wl"},    32'(wl[0]),   32'h0);
  endtask

  logic [7:0]  img [12];
  logic [31:0] words [3];
  logic        ok;
  logic        seen;
  logic        saw_ready;
  int          st;
  int          at;
  int          h;
  int          hs_before;

  initial begin
    img   = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE,
              8'h12, 8'h34, 8'h56, 8'h78};
    words = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678};
    n_pass = 0; n_total = 0; viol = 0; cyc = 0; log_n = 0;
    for (int k = 0; k < 3; k++) begin
      hs[k] = 0;
      start_q[k] = 1'b0;
      for (int i = 0; i < 512; i++) mem[k][i] = 8'h00;
    end
    clr_mem = 1'b0;
    word_valid = 1'b0; word_data = 32'h0; word_last = 1'b0;

    // Reset state.
    #2;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic load, valid held high.
    pulse_start(0, st);
    check("ready_after_start", 32'(wr[0]), 32'h1);
    for (int i = 0; i < 3; i++) begin
      send_word(0, words[i], (i == 2), 0, ok);
      check("basic_hs", 32'(ok), 32'h1);
    end
    wait_done(0, at, seen);
    check("basic_done_seen", 32'(seen), 32'h1);
    check("basic_done_cycle", 32'(at - st), 32'd15);
    check("basic_wl", 32'(wl[0]), 32'd3);
    check("basic_ovf", 32'(ovf[0]), 32'h0);
    @(negedge clk);
    check("basic_busy_after", 32'(busy[0]), 32'h0);
    for (int i = 0; i < 12; i++) check("basic_byte", 32'(mem[0][i]), 32'(img[i]));
    for (int i = 0; i < 3; i++)
      check("basic_read", {mem[0][4*i], mem[0][4*i+1], mem[0][4*i+2], mem[0][4*i+3]}, words[i]);
    check("basic_hs_count", 32'(hs[0]), 32'd3);

    // Same words with random valid gaps into a cleared memory.
    @(negedge clk); clr_mem = 1'b1;
    @(negedge clk); clr_mem = 1'b0;
    hs_before = hs[0];
    pulse_start(0, st);
    for (int i = 0; i < 3; i++) begin
      send_word(0, words[i], (i == 2), int'($urandom_range(0, 3)), ok);
      check("gap_hs", 32'(ok), 32'h1);
    end
    word_valid = 1'b0;
    wait_done(0, at, seen);
    check("gap_done_seen", 32'(seen), 32'h1);
    check("gap_wl", 32'(wl[0]), 32'd3);
    check("gap_hs_count", 32'(hs[0] - hs_before), 32'd3);
    for (int i = 0; i < 12; i++) check("gap_byte", 32'(mem[0][i]), 32'(img[i]));
    check("ready_during_write", 32'(viol), 32'd0);

    // Overflow: 8-byte space, third word refused.
    pulse_start(1, st);
    for (int i = 0; i < 2; i++) begin
      send_word(1, words[i], 1'b0, 0, ok);
      check("ovf_hs", 32'(ok), 32'h1);
    end
    h = cyc;
    @(negedge clk);
    word_valid = 1'b1; word_data = words[2]; word_last = 1'b1;
    saw_ready = 1'b0; seen = 1'b0; at = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (wr[1]) saw_ready = 1'b1;
      if (done[1]) begin
        seen = 1'b1;
        at = cyc;
        check("ovf_flag_at_done", 32'(ovf[1]), 32'h1);
      end else begin
        @(negedge clk);
      end
    end
    check("ovf_done_seen", 32'(seen), 32'h1);
    check("ovf_done_cycle", 32'(at - h), 32'd5);
    check("ovf_ready_refused", 32'(saw_ready), 32'h0);
    check("ovf_wl", 32'(wl[1]), 32'd2);
    check("ovf_hs_count", 32'(hs[1]), 32'd2);
    for (int i = 0; i < 8; i++) check("ovf_byte", 32'(mem[1][i]), 32'(img[i]));
    check("ovf_byte8_untouched", 32'(mem[1][8]), 32'h0);
    @(negedge clk);
    check("ovf_idle_busy", 32'(busy[1]), 32'h0);
    check("ovf_sticky", 32'(ovf[1]), 32'h1);
    pulse_start(1, st);
    check("ovf_cleared", 32'(ovf[1]), 32'h0);
    check("ovf_wl_cleared", 32'(wl[1]), 32'h0);
    send_word(1, 32'h01020304, 1'b1, 0, ok);
    check("ovf2_hs", 32'(ok), 32'h1);
    wait_done(1, at, seen);
    check("ovf2_done_seen", 32'(seen), 32'h1);
    check("ovf2_wl", 32'(wl[1]), 32'd1);
    check("ovf2_ovf", 32'(ovf[1]), 32'h0);

    // BASE_ADDR = 16, single word.
    pulse_start(2, st);
    send_word(2, 32'h0A0B0C0D, 1'b1, 0, ok);
    check("base_hs", 32'(ok), 32'h1);
    wait_done(2, at, seen);
    check("base_done_seen", 32'(seen), 32'h1);
    check("base_write_count", 32'(log_n), 32'd4);
    check("base_addr0", log_addr[0], 32'd16);
    check("base_addr1", log_addr[1], 32'd17);
    check("base_addr2", log_addr[2], 32'd18);
    check("base_addr3", log_addr[3], 32'd19);
    check("base_data0", 32'(log_data[0]), 32'h0A);
    check("base_data1", 32'(log_data[1]), 32'h0B);
    check("base_data2", 32'(log_data[2]), 32'h0C);
    check("base_data3", 32'(log_data[3]), 32'h0D);
    check("base_read", {mem[2][16], mem[2][17], mem[2][18], mem[2][19]}, 32'h0A0B0C0D);
    check("base_wl", 32'(wl[2]), 32'd1);

    // start pulsed during WRITE is ignored.
    hs_before = hs[0];
    pulse_start(0, st);
    send_word(0, 32'h11223344, 1'b0, 0, ok);
    check("sw_hs1", 32'(ok), 32'h1);
    @(negedge clk);
    start_q[0] = 1'b1;
    @(posedge clk);
    #1;
    start_q[0] = 1'b0;
    check("sw_busy", 32'(busy[0]), 32'h1);
    check("sw_addr_continues", addr[0], 32'd1);
    send_word(0, 32'h55667788, 1'b1, 0, ok);
    check("sw_hs2", 32'(ok), 32'h1);
    wait_done(0, at, seen);
    check("sw_done_seen", 32'(seen), 32'h1);
    check("sw_wl", 32'(wl[0]), 32'd2);
    check("sw_hs_count", 32'(hs[0] - hs_before), 32'd2);
    check("sw_word0", {mem[0][0], mem[0][1], mem[0][2], mem[0][3]}, 32'h11223344);
    check("sw_word1", {mem[0][4], mem[0][5], mem[0][6], mem[0][7]}, 32'h55667788);
    check("sw_word2", {mem[0][8], mem[0][9], mem[0][10], mem[0][11]}, 32'h12345678);

    // Reset asserted in the middle of beat 2.
    pulse_start(0, st);
    send_word(0, 32'hAABBCCDD, 1'b0, 0, ok);
    check("rw_hs", 32'(ok), 32'h1);
    word_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rw_beat2_addr", addr[0], 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rw");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rw_byte0", 32'(mem[0][0]), 32'hAA);
    check("rw_byte1", 32'(mem[0][1]), 32'hBB);
    check("rw_byte2_kept", 32'(mem[0][2]), 32'h33);
    check("rw_byte3_kept", 32'(mem[0][3]), 32'h44);
    pulse_start(0, st);
    send_word(0, 32'h0F0E0D0C, 1'b1, 0, ok);
    check("rw2_hs", 32'(ok), 32'h1);
    check("rw2_first_addr", addr[0], 32'd0);
    check("rw2_first_data", 32'(wdata[0]), 32'h0F);
    wait_done(0, at, seen);
    check("rw2_done_seen", 32'(seen), 32'h1);
    check("rw2_word", {mem[0][0], mem[0][1], mem[0][2], mem[0][3]}, 32'h0F0E0D0C);
    check("rw2_wl", 32'(wl[0]), 32'd1);
    check("final_ready_during_write", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
